// File: rtl/axil_core_ctrl_regs.sv
// AXI4-Lite register bank: ID/version/scratch, RISC-V core reset/halt control and status.
// Optional 64-bit cycle counter at 0x018/0x01C when CORE_CTRL_CYCLE_CNT_EN is defined.
module axil_core_ctrl_regs #(
    parameter int unsigned ADDR_W   = 12,
    parameter logic [31:0] ID_VALUE = 32'hC0DE_0002,
    parameter logic [31:0] VERSION  = 32'h0001_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [31:0]       s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic              core_reset_o,
    output logic              core_halt_o,
    input  logic              core_trap_i
);
    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [IDX_W-1:0] IDX_ID       = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_VERSION  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_SCRATCH  = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_CONTROL  = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_CYCLE_LO = IDX_W'(6);
    localparam logic [IDX_W-1:0] IDX_CYCLE_HI = IDX_W'(7);

    logic             aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [3:0]       w_strb_q, w_strb_d;
    logic             awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic             bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]       bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             trap_q, trap_d;
`ifdef CORE_CTRL_CYCLE_CNT_EN
    logic [63:0]      cnt_q, cnt_d;
    logic [31:0]      hi_shadow_q, hi_shadow_d;
    logic             cnt_clr;
`endif

    logic             aw_hs, w_hs, ar_hs, commit, wr_ok, trap_clr, rd_ok;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [31:0]      wr_data, rd_val;
    logic [3:0]       wr_strb;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    assign aw_hs   = s_axil_awvalid & awready_q;
    assign w_hs    = s_axil_wvalid & wready_q;
    assign ar_hs   = s_axil_arvalid & arready_q;
    // Incoming beats bypass the holding regs so a joint AW+W handshake commits at once.
    assign wr_idx  = aw_held_q ? aw_idx_q : s_axil_awaddr[ADDR_W-1:2];
    assign wr_data = w_held_q ? w_data_q : s_axil_wdata;
    assign wr_strb = w_held_q ? w_strb_q : s_axil_wstrb;
    assign commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
    assign rd_idx  = s_axil_araddr[ADDR_W-1:2];

    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b1;
        case (rd_idx)
            IDX_ID:       rd_val = ID_VALUE;
            IDX_VERSION:  rd_val = VERSION;
            IDX_SCRATCH:  rd_val = scratch_q;
            IDX_CONTROL:  rd_val = {30'd0, ctrl_q};
            IDX_STATUS:   rd_val = {29'd0, trap_q, ctrl_q[1], ctrl_q[0]};
`ifdef CORE_CTRL_CYCLE_CNT_EN
            IDX_CYCLE_LO: rd_val = cnt_q[31:0];
            IDX_CYCLE_HI: rd_val = hi_shadow_q;
`endif
            default:      rd_ok  = 1'b0;
        endcase
    end

    always_comb begin
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        trap_clr  = 1'b0;
        wr_ok     = 1'b1;
`ifdef CORE_CTRL_CYCLE_CNT_EN
        cnt_clr   = 1'b0;
`endif
        if (commit) begin
            case (wr_idx)
                IDX_ID, IDX_VERSION: ;
                IDX_SCRATCH: begin
                    for (int b = 0; b < 4; b++)
                        if (wr_strb[b]) scratch_d[8*b +: 8] = wr_data[8*b +: 8];
                end
                IDX_CONTROL: begin
                    if (wr_strb[0]) begin
                        ctrl_d = wr_data[1:0];
`ifdef CORE_CTRL_CYCLE_CNT_EN
                        cnt_clr = wr_data[0];
`endif
                    end
                end
                IDX_STATUS:  trap_clr = wr_strb[0] & wr_data[2];
`ifdef CORE_CTRL_CYCLE_CNT_EN
                IDX_CYCLE_LO, IDX_CYCLE_HI: ;
`endif
                default:     wr_ok = 1'b0;
            endcase
        end
        // A trap arriving with the W1C keeps the sticky bit set.
        trap_d = core_trap_i | (trap_q & ~trap_clr);
    end

    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s_axil_awaddr[ADDR_W-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = s_axil_wdata;
            w_strb_d = s_axil_wstrb;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        bvalid_d  = (bvalid_q & ~s_axil_bready) | commit;
        bresp_d   = commit ? (wr_ok ? RESP_OKAY : RESP_SLVERR) : bresp_q;
        awready_d = ~aw_held_d & ~bvalid_d;
        wready_d  = ~w_held_d & ~bvalid_d;
        rvalid_d  = (rvalid_q & ~s_axil_rready) | ar_hs;
        rdata_d   = ar_hs ? rd_val : rdata_q;
        rresp_d   = ar_hs ? (rd_ok ? RESP_OKAY : RESP_SLVERR) : rresp_q;
        arready_d = ~rvalid_d;
    end

`ifdef CORE_CTRL_CYCLE_CNT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (!ctrl_q[0])
            cnt_d = cnt_q + 64'd1;
        // Reading LO freezes the matching HI word for a coherent 64-bit read.
        hi_shadow_d = (ar_hs && rd_idx == IDX_CYCLE_LO) ? cnt_q[63:32] : hi_shadow_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            scratch_q <= '0;
            ctrl_q    <= 2'b01;
            trap_q    <= 1'b0;
`ifdef CORE_CTRL_CYCLE_CNT_EN
            cnt_q       <= '0;
            hi_shadow_q <= '0;
`endif
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            trap_q    <= trap_d;
`ifdef CORE_CTRL_CYCLE_CNT_EN
            cnt_q       <= cnt_d;
            hi_shadow_q <= hi_shadow_d;
`endif
        end
    end

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_arready = arready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;
    assign core_reset_o   = ctrl_q[0];
    assign core_halt_o    = ctrl_q[1];
endmodule
